// File: rtl/dmem_ctrl.sv
// Data-memory controller: word RAM plus memory-mapped GPIO and a compare/match timer.
// Reads are combinational from daddr/d_r; all state updates on the rising edge of CLK.
module dmem_ctrl #(
  parameter int unsigned RAM_WORDS = 1008,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [9:0]        daddr,
  input  logic [31:0]       ddata_w,
  input  logic              d_w,
  input  logic              d_r,
  output logic [31:0]       ddata_r,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  localparam logic [9:0] A_GPIO_OUT = 10'h3F0;
  localparam logic [9:0] A_GPIO_IN  = 10'h3F1;
  localparam logic [9:0] A_TCOUNT   = 10'h3F2;
  localparam logic [9:0] A_TCMP     = 10'h3F3;
  localparam logic [9:0] A_TCTRL    = 10'h3F4;

  logic [31:0]       mem [RAM_WORDS];
  logic [GPIO_W-1:0] sync1_q, sync2_q;
  logic [31:0]       tcount_q, tcmp_q;
  logic              en_q, match_q, ie_q;

  logic              ram_sel_c;
  logic [RAM_AW-1:0] ram_idx_c;
  logic              wr_gpo_c, wr_tcount_c, wr_tcmp_c, wr_tctrl_c;
  logic              match_hit_c;

  assign ram_sel_c   = (32'(daddr) < RAM_WORDS);
  assign ram_idx_c   = RAM_AW'(daddr);
  assign wr_gpo_c    = d_w && (daddr == A_GPIO_OUT);
  assign wr_tcount_c = d_w && (daddr == A_TCOUNT);
  assign wr_tcmp_c   = d_w && (daddr == A_TCMP);
  assign wr_tctrl_c  = d_w && (daddr == A_TCTRL);
  assign match_hit_c = en_q && (tcount_q == tcmp_q);

  // RAM has no reset; its contents survive RSTn
  always_ff @(posedge CLK) begin
    if (d_w && ram_sel_c) mem[ram_idx_c] <= ddata_w;
  end

  // Read mux: pre-write values are visible because all storage updates on the edge
  always_comb begin
    ddata_r = 32'h0;
    if (d_r) begin
      if (ram_sel_c) begin
        ddata_r = mem[ram_idx_c];
      end else begin
        case (daddr)
          A_GPIO_OUT: ddata_r = 32'(gpio_out);
          A_GPIO_IN:  ddata_r = 32'(sync2_q);
          A_TCOUNT:   ddata_r = tcount_q;
          A_TCMP:     ddata_r = tcmp_q;
          A_TCTRL:    ddata_r = {29'h0, ie_q, match_q, en_q};
          default:    ddata_r = 32'h0;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      gpio_out <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      if (wr_gpo_c) gpio_out <= ddata_w[GPIO_W-1:0];
    end
  end

  // Timer: core write beats reload/increment; MATCH set beats a coincident W1C
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tcount_q <= 32'h0;
      tcmp_q   <= 32'hFFFF_FFFF;
      en_q     <= 1'b0;
      match_q  <= 1'b0;
      ie_q     <= 1'b0;
    end else begin
      if (wr_tcount_c)      tcount_q <= ddata_w;
      else if (match_hit_c) tcount_q <= 32'h0;
      else if (en_q)        tcount_q <= tcount_q + 32'd1;

      if (wr_tcmp_c) tcmp_q <= ddata_w;

      if (wr_tctrl_c) begin
        en_q <= ddata_w[0];
        ie_q <= ddata_w[2];
      end

      if (match_hit_c)                    match_q <= 1'b1;
      else if (wr_tctrl_c && ddata_w[1])  match_q <= 1'b0;
    end
  end

  assign timer_irq = match_q & ie_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: RAM, GPIO, timer priority rules and async reset.
module tb_dmem_ctrl;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [9:0]  daddr;
  logic [31:0] ddata_w;
  logic        d_w, d_r;
  logic [31:0] ddata_r;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  int vectors = 0;
  int miscompares = 0;

  dmem_ctrl #(.RAM_WORDS(1008), .GPIO_W(8)) dut (
    .CLK(CLK), .RSTn(RSTn), .daddr(daddr), .ddata_w(ddata_w), .d_w(d_w), .d_r(d_r),
    .ddata_r(ddata_r), .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Steps start 1 time unit after a rising edge and end at the same phase
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    daddr = a; ddata_w = d; d_w = 1'b1; d_r = 1'b0;
    tick();
    d_w = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] exp, input string tag);
    daddr = a; d_r = 1'b1; d_w = 1'b0;
    #1;
    chk(ddata_r, exp, tag);
    d_r = 1'b0;
  endtask

  initial begin
    RSTn = 1'b0; daddr = '0; ddata_w = '0; d_w = 1'b0; d_r = 1'b0; gpio_in = 8'h00;
    tick();
    chk(32'(gpio_out), 32'h0, "rst_gpio_out");
    chk(32'(timer_irq), 32'h0, "rst_irq");
    rd(10'h3F2, 32'h0, "rst_tcount");
    rd(10'h3F3, 32'hFFFF_FFFF, "rst_tcmp");
    rd(10'h3F4, 32'h0, "rst_tctrl");
    RSTn = 1'b1;
    tick();

    // RAM write then read; d_r low forces zero
    wr(10'h005, 32'hDEAD_BEEF);
    rd(10'h005, 32'hDEAD_BEEF, "ram_rd5");
    daddr = 10'h005; d_r = 1'b0; #1;
    chk(ddata_r, 32'h0, "ram_dr0");

    // Simultaneous read+write returns the pre-write value
    wr(10'h006, 32'h1111_1111);
    daddr = 10'h006; ddata_w = 32'h2222_2222; d_w = 1'b1; d_r = 1'b1; #1;
    chk(ddata_r, 32'h1111_1111, "rw_prewrite");
    tick();
    d_w = 1'b0;
    rd(10'h006, 32'h2222_2222, "rw_postwrite");
    wr(10'h3EF, 32'hCAFE_F00D);
    rd(10'h3EF, 32'hCAFE_F00D, "ram_top");

    // GPIO out truncation and input synchroniser latency
    wr(10'h3F0, 32'h0000_01A5);
    chk(32'(gpio_out), 32'hA5, "gpio_out");
    rd(10'h3F0, 32'h0000_00A5, "gpio_out_rd");
    gpio_in = 8'h3C;
    rd(10'h3F1, 32'h0, "gpio_in_e0");
    tick();
    rd(10'h3F1, 32'h0, "gpio_in_e1");
    tick();
    rd(10'h3F1, 32'h3C, "gpio_in_e2");
    wr(10'h3F1, 32'hFF);
    rd(10'h3F1, 32'h3C, "gpio_in_ro");

    // Timer period TCMP+1 with match and irq
    wr(10'h3F3, 32'd3);
    wr(10'h3F4, 32'h5);
    rd(10'h3F2, 32'd0, "tc_0");
    tick(); rd(10'h3F2, 32'd1, "tc_1");
    tick(); rd(10'h3F2, 32'd2, "tc_2");
    tick(); rd(10'h3F2, 32'd3, "tc_3");
    chk(32'(timer_irq), 32'h0, "irq_pre");
    tick(); rd(10'h3F2, 32'd0, "tc_wrap");
    chk(32'(timer_irq), 32'h1, "irq_set");
    rd(10'h3F4, 32'h7, "tctrl_match");

    // W1C MATCH and disable; the old EN still increments on that edge
    wr(10'h3F4, 32'h2);
    rd(10'h3F4, 32'h0, "tctrl_clr");
    chk(32'(timer_irq), 32'h0, "irq_clr");
    rd(10'h3F2, 32'd1, "tc_lastinc");
    tick();
    rd(10'h3F2, 32'd1, "tc_stopped");

    // Core TCOUNT write coincident with match: write wins, MATCH still sets
    wr(10'h3F4, 32'h5);
    rd(10'h3F2, 32'd1, "tc_en_edge");
    tick(); tick();
    rd(10'h3F2, 32'd3, "tc_at_cmp");
    wr(10'h3F2, 32'd100);
    rd(10'h3F2, 32'd100, "tc_wr_prio");
    rd(10'h3F4, 32'h7, "match_w_prio");

    // W1C coincident with match: set wins
    wr(10'h3F4, 32'h7);
    rd(10'h3F4, 32'h5, "match_w1c");
    chk(32'(timer_irq), 32'h0, "irq_w1c");
    wr(10'h3F2, 32'd2);
    tick();
    rd(10'h3F2, 32'd3, "tc_at_cmp2");
    wr(10'h3F4, 32'h7);
    rd(10'h3F4, 32'h7, "match_set_wins");
    rd(10'h3F2, 32'd0, "tc_reload2");

    // Unmapped accesses
    wr(10'h3FA, 32'h1234_5678);
    rd(10'h3FA, 32'h0, "unmapped");
    rd(10'h3F5, 32'h0, "unmapped2");

    // 32-bit wrap without match
    wr(10'h3F3, 32'd5);
    wr(10'h3F4, 32'h2);
    wr(10'h3F2, 32'hFFFF_FFFE);
    wr(10'h3F4, 32'h1);
    rd(10'h3F2, 32'hFFFF_FFFE, "wrap_0");
    tick(); rd(10'h3F2, 32'hFFFF_FFFF, "wrap_1");
    tick(); rd(10'h3F2, 32'h0, "wrap_2");
    rd(10'h3F4, 32'h1, "wrap_nomatch");

    // Async reset mid-count: registers reset immediately, RAM retained
    wr(10'h3F4, 32'h5);
    tick();
    RSTn = 1'b0; #1;
    chk(32'(gpio_out), 32'h0, "ar_gpio_out");
    chk(32'(timer_irq), 32'h0, "ar_irq");
    rd(10'h3F2, 32'h0, "ar_tcount");
    rd(10'h3F3, 32'hFFFF_FFFF, "ar_tcmp");
    rd(10'h3F4, 32'h0, "ar_tctrl");
    rd(10'h3F1, 32'h0, "ar_sync");
    rd(10'h005, 32'hDEAD_BEEF, "ar_ram");
    wr(10'h3F3, 32'd7);
    rd(10'h3F3, 32'hFFFF_FFFF, "ar_wr_blocked");
    RSTn = 1'b1;
    tick();
    rd(10'h3F2, 32'h0, "post_rst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1008, number of 32-bit RAM words at word addresses 0..RAM_WORDS-1 (max 1008).
REQ-002 SHALL have parameter GPIO_W, default 8, width of GPIO in/out ports (1..32).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RSTn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port daddr  input  10  word address from core.
REQ-006 SHALL have port ddata_w  input  32  write data from core.
REQ-007 SHALL have port d_w  input  1  write strobe; write committed at the next rising edge.
REQ-008 SHALL have port d_r  input  1  read strobe.
REQ-009 SHALL have port ddata_r  output  32  read data; combinational from daddr/d_r, same cycle.
REQ-010 SHALL have port gpio_in  input  GPIO_W  asynchronous external inputs.
REQ-011 SHALL have port gpio_out  output  GPIO_W  registered GPIO output.
REQ-012 SHALL have port timer_irq  output  1  level interrupt, registered-state derived.

Function
REQ-013 SHALL decode the word address map: 0x000..RAM_WORDS-1 RAM; 0x3F0 GPIO_OUT (rw); 0x3F1 GPIO_IN (ro); 0x3F2 TCOUNT (rw); 0x3F3 TCMP (rw); 0x3F4 TCTRL (rw); all other addresses unmapped.
REQ-014 SHALL write a RAM word on rising edge when d_w=1 and the address is in RAM; read is asynchronous, so a same-cycle read returns the pre-write value.
REQ-015 SHALL drive ddata_r=0 when d_r=0 or the address is unmapped; unmapped writes SHALL be ignored.
REQ-016 SHALL zero-extend GPIO_OUT and GPIO_IN to 32 bits on read; writes to GPIO_OUT take ddata_w[GPIO_W-1:0]; writes to GPIO_IN are ignored.
REQ-017 SHALL synchronise gpio_in through two flops; GPIO_IN reads return the second stage (2-cycle latency).
REQ-018 SHALL implement TCTRL bits: [0] EN (rw), [1] MATCH (sticky, write-1-to-clear), [2] IE (rw); bits [31:3] read 0.
REQ-019 SHALL increment TCOUNT by 1 per cycle while EN=1, wrapping 0xFFFFFFFF->0.
REQ-020 SHALL, when EN=1 and TCOUNT==TCMP, load TCOUNT=0 and set MATCH on that edge (period = TCMP+1 cycles).
REQ-021 SHALL give a core write to TCOUNT priority over increment/match-reload in the same cycle.
REQ-022 SHALL, if a MATCH set and a W1C of MATCH occur in the same cycle, leave MATCH=1 (set wins).
REQ-023 SHALL apply a TCTRL write of EN/IE on the edge; a write changing EN does not suppress a match evaluated in that cycle on the old EN.
REQ-024 SHALL drive timer_irq = MATCH & IE, with no combinational path from core inputs.
REQ-025 SHALL, if d_w and d_r are both 1, perform the write and return the pre-write value on ddata_r.

Reset
REQ-026 SHALL on RSTn=0, asynchronously: gpio_out=0, sync flops=0, TCOUNT=0, TCMP=0xFFFFFFFF, TCTRL=0, timer_irq=0.
REQ-027 SHALL leave RAM contents unchanged by reset; reset asserted mid-write SHALL suppress register writes but RAM content at that address is undefined.
REQ-028 SHALL keep ddata_r purely combinational under reset (RAM reads valid; register reads return reset values).

Verification
REQ-029 RAM: write 0xDEADBEEF to 0x005, next cycle read 0x005 -> ddata_r=0xDEADBEEF; read 0x005 with d_r=0 -> 0.
REQ-030 GPIO: write 0x1A5 to 0x3F0 -> gpio_out=0xA5 (GPIO_W=8); gpio_in=0x3C -> read 0x3F1 gives 0x3C exactly 2 edges later, 0 before.
REQ-031 Timer: TCMP=3, TCTRL=0x5 -> TCOUNT 0,1,2,3,0; MATCH and timer_irq=1 after the 3->0 edge; write 0x2 to TCTRL clears MATCH and disables timer.
REQ-032 Priority: with EN=1, write TCOUNT=100 in the cycle TCOUNT==TCMP -> TCOUNT=100, MATCH still set; W1C coincident with match -> MATCH stays 1.
REQ-033 Unmapped/reset: write to 0x3FA then read -> 0; assert RSTn low mid-count -> all registers at REQ-026 values immediately, RAM word 0x005 retains 0xDEADBEEF.
